// File: rtl/tmds_channel_enc_pkg.sv
// -----------------------------------------------------------------------------
// tmds_channel_enc_pkg
// Shared definitions for the TMDS channel encoder:
//   - SYM_W        : width of one encoded TMDS symbol (10 bits)
//   - TOK_C00..C11 : the four control-period tokens, indexed by {c1,c0}
//   - disp_t       : 5-bit signed running-disparity type
//   - s1_t         : bundle of values handed from stage 1 to stage 2
//   - ctrl_token() : maps {c1,c0} to its control token
// -----------------------------------------------------------------------------
package tmds_channel_enc_pkg;

    localparam int SYM_W = 10;

    // Control tokens, bit 0 is serialized first.
    localparam logic [SYM_W-1:0] TOK_C00 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_C01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_C10 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_C11 = 10'h2AB;

    // Running disparity (ones minus zeros over the sent symbols).
    // Legal stream values stay within -8..+8, so 5 bits signed is enough.
    typedef logic signed [4:0] disp_t;

    // Stage-1 result: transition-minimised word plus its popcounts, and
    // the blank/control qualifiers travelling alongside it.
    typedef struct packed {
        logic [8:0] q_m;
        logic       blank;
        logic [1:0] ctrl;
        logic [3:0] n1q;
        logic [3:0] n0q;
    } s1_t;

    // Stage-1 contents after reset: a blank slot carrying control 00.
    // q_m is all zeros, so its zero count is 8.
    localparam s1_t S1_RESET = '{
        q_m:   9'h000,
        blank: 1'b1,
        ctrl:  2'b00,
        n1q:   4'd0,
        n0q:   4'd8
    };

    // Map the control bits {c1,c0} to the token sent during blanking.
    function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] ctrl);
        logic [SYM_W-1:0] tok;
        case (ctrl)
            2'b00:   tok = TOK_C00;
            2'b01:   tok = TOK_C01;
            2'b10:   tok = TOK_C10;
            2'b11:   tok = TOK_C11;
            default: tok = TOK_C00;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_channel_enc_popcnt8.sv
// -----------------------------------------------------------------------------
// tmds_popcnt8
// Combinational population count of an 8-bit word.
//   data  : input,  8 bits - word to count
//   count : output, 4 bits - number of ones in data (0..8)
// -----------------------------------------------------------------------------
module tmds_popcnt8 (
    input  logic [7:0] data,
    output logic [3:0] count
);

    // Sum the individual bits of the word.
    always_comb begin
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, data[i]};
        end
        count = sum;
    end

endmodule

// File: rtl/tmds_channel_enc.sv
// -----------------------------------------------------------------------------
// tmds_channel_enc
// One DVI/HDMI TMDS lane encoder (8b -> 10b). Three instances, one each for
// the blue, green and red lanes, feed the downstream 10:1 serializers.
//
// Stage 1 turns the pixel byte into a transition-minimised 9-bit word q_m
// and counts its ones/zeros. Stage 2 chooses whether to invert q_m[7:0] so
// the running disparity drifts back toward zero, or emits a control token
// during blanking.
//
// Parameters:
//   PIPE_EN : 1 = stage 1 is registered (latency 2)
//             0 = stage 1 is combinational (latency 1)
// Ports:
//   clk_i   : input,  1  - pixel clock (single clock domain)
//   rst_i   : input,  1  - synchronous active-high reset
//   data_i  : input,  8  - pixel colour component
//   blank_i : input,  1  - high outside the active video area
//   ctrl_i  : input,  2  - control bits {c1,c0} (blue lane: {vsync,hsync})
//   tmds_o  : output, 10 - encoded TMDS symbol, bit 0 serialized first
// -----------------------------------------------------------------------------
module tmds_channel_enc
    import tmds_channel_enc_pkg::*;
#(
    parameter bit PIPE_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             blank_i,
    input  logic [1:0]       ctrl_i,
    output logic [SYM_W-1:0] tmds_o
);

    // ------------------------------------------------------------------
    // Stage 1: transition minimisation
    // ------------------------------------------------------------------
    logic [3:0] n1_d_s;     // ones in the incoming byte
    logic       use_xnor_s; // chain with XNOR instead of XOR
    logic [8:0] q_m_s;
    logic [3:0] n1q_s;      // ones in q_m[7:0]
    s1_t        s1_s;       // stage-1 result, combinational
    s1_t        s1_v;       // stage-1 result as seen by stage 2

    tmds_popcnt8 u_popcnt_data (
        .data  (data_i),
        .count (n1_d_s)
    );

    // XNOR chaining when the byte is ones-heavy; a tie of four ones falls
    // to XNOR only when bit 0 is zero.
    assign use_xnor_s = (n1_d_s > 4'd4) ||
                        ((n1_d_s == 4'd4) && (data_i[0] == 1'b0));

    // Build q_m bit by bit; q_m[8] records which chaining was used.
    always_comb begin
        logic [8:0] q;
        q = 9'h000;
        q[0] = data_i[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor_s) begin
                q[i] = ~(q[i-1] ^ data_i[i]);
            end else begin
                q[i] = q[i-1] ^ data_i[i];
            end
        end
        q[8] = ~use_xnor_s;
        q_m_s = q;
    end

    tmds_popcnt8 u_popcnt_qm (
        .data  (q_m_s[7:0]),
        .count (n1q_s)
    );

    assign s1_s = '{
        q_m:   q_m_s,
        blank: blank_i,
        ctrl:  ctrl_i,
        n1q:   n1q_s,
        n0q:   4'd8 - n1q_s
    };

    generate
        if (PIPE_EN) begin : g_pipe
            s1_t s1_r;

            // Stage-1 pipeline register; q_m, popcounts and qualifiers move
            // together so stage 2 never mixes slots.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_r <= S1_RESET;
                end else begin
                    s1_r <= s1_s;
                end
            end

            assign s1_v = s1_r;
        end else begin : g_comb
            assign s1_v = s1_s;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: DC balancing and control tokens
    // ------------------------------------------------------------------
    disp_t            cnt_r;      // running disparity
    logic [SYM_W-1:0] tmds_r;
    disp_t            n1q_sd_s;   // popcounts widened to signed
    disp_t            n0q_sd_s;
    disp_t            diff_s;     // N1q - N0q
    disp_t            cnt_nxt_s;
    logic [SYM_W-1:0] sym_nxt_s;
    logic             q8_s;
    logic [7:0]       q_s;

    assign q8_s     = s1_v.q_m[8];
    assign q_s      = s1_v.q_m[7:0];
    assign n1q_sd_s = {1'b0, s1_v.n1q};
    assign n0q_sd_s = {1'b0, s1_v.n0q};
    assign diff_s   = n1q_sd_s - n0q_sd_s;

    // Select the next symbol and the disparity it leaves behind. Bit 9
    // flags inversion of the data bits, bit 8 carries the chaining type,
    // so the disparity change equals the ones-minus-zeros of the symbol.
    always_comb begin
        sym_nxt_s = TOK_C00;
        cnt_nxt_s = 5'sd0;
        if (s1_v.blank) begin
            // Blanking restarts the balance so the next line starts fresh.
            sym_nxt_s = ctrl_token(s1_v.ctrl);
            cnt_nxt_s = 5'sd0;
        end else if ((cnt_r == 5'sd0) || (s1_v.n1q == s1_v.n0q)) begin
            // No preferred direction: invert only for XNOR-chained words.
            if (q8_s) begin
                sym_nxt_s = {1'b0, 1'b1, q_s};
                cnt_nxt_s = cnt_r + diff_s;
            end else begin
                sym_nxt_s = {1'b1, 1'b0, ~q_s};
                cnt_nxt_s = cnt_r - diff_s;
            end
        end else if (((cnt_r > 5'sd0) && (s1_v.n1q > s1_v.n0q)) ||
                     ((cnt_r < 5'sd0) && (s1_v.n0q > s1_v.n1q))) begin
            // Word would push further the same way: send it inverted.
            sym_nxt_s = {1'b1, q8_s, ~q_s};
            if (q8_s) begin
                cnt_nxt_s = cnt_r + 5'sd2 - diff_s;
            end else begin
                cnt_nxt_s = cnt_r - diff_s;
            end
        end else begin
            // Word already pulls toward balance: send it as is.
            sym_nxt_s = {1'b0, q8_s, q_s};
            if (q8_s) begin
                cnt_nxt_s = cnt_r + diff_s;
            end else begin
                cnt_nxt_s = cnt_r + diff_s - 5'sd2;
            end
        end
    end

    // Output symbol and running disparity registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmds_r <= TOK_C00;
            cnt_r  <= 5'sd0;
        end else begin
            tmds_r <= sym_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign tmds_o = tmds_r;

endmodule

// File: tb/tb_tmds_channel_enc.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_enc
// Drives one latency-2 (PIPE_EN=1) and one latency-1 (PIPE_EN=0) encoder
// from the same inputs and checks both against hand-computed symbol and
// disparity tables, plus a decode/disparity check on random active data.
// -----------------------------------------------------------------------------
module tb_tmds_channel_enc;

    logic       clk;
    logic       rst_i;
    logic [7:0] data_i;
    logic       blank_i;
    logic [1:0] ctrl_i;
    logic [9:0] tmds1;
    logic [9:0] tmds0;

    int n_tests;
    int n_fail;

    tmds_channel_enc #(.PIPE_EN(1'b1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .blank_i (blank_i),
        .ctrl_i  (ctrl_i),
        .tmds_o  (tmds1)
    );

    tmds_channel_enc #(.PIPE_EN(1'b0)) dut0 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .blank_i (blank_i),
        .ctrl_i  (ctrl_i),
        .tmds_o  (tmds0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold blanking with control 00 for n cycles (no checks).
    task automatic go_blank(input int n);
        blank_i = 1'b1;
        ctrl_i  = 2'b00;
        data_i  = 8'h00;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int pop10(input logic [9:0] s);
        int c;
        c = 0;
        for (int i = 0; i < 10; i++) c = c + int'(s[i]);
        return c;
    endfunction

    // Receiver-side TMDS data decode.
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    function automatic int cnt_of1();
        return int'($signed(dut1.cnt_r));
    endfunction

    function automatic int cnt_of0();
        return int'($signed(dut0.cnt_r));
    endfunction

    task automatic test_reset();
        rst_i   = 1'b1;
        blank_i = 1'b0;
        ctrl_i  = 2'b11;
        data_i  = 8'hA5;
        step();
        step();
        n_tests++;
        if (tmds1 !== 10'h354) begin
            n_fail++; $display("FAIL reset_sym_p1: got %h expected %h", tmds1, 10'h354);
        end
        n_tests++;
        if (tmds0 !== 10'h354) begin
            n_fail++; $display("FAIL reset_sym_p0: got %h expected %h", tmds0, 10'h354);
        end
        n_tests++;
        if (cnt_of1() != 0 || cnt_of0() != 0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0", cnt_of1(), cnt_of0());
        end
        rst_i   = 1'b0;
        blank_i = 1'b1;
        ctrl_i  = 2'b00;
        data_i  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (tmds1 !== 10'h354 || tmds0 !== 10'h354) begin
                n_fail++; $display("FAIL idle_blank[%0d]: got %h/%h expected 354", i, tmds1, tmds0);
            end
            n_tests++;
            if (cnt_of1() != 0 || cnt_of0() != 0) begin
                n_fail++; $display("FAIL idle_cnt[%0d]: got %0d/%0d expected 0", i, cnt_of1(), cnt_of0());
            end
        end
    endtask

    task automatic test_ctrl_tokens();
        logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        logic [9:0] e1;
        go_blank(2);
        blank_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ctrl_i = (i < 4) ? 2'(i) : 2'b11;
            step();
            if (i < 4) begin
                n_tests++;
                if (tmds0 !== tok[i]) begin
                    n_fail++; $display("FAIL ctrl_tok_p0[%0d]: got %h expected %h", i, tmds0, tok[i]);
                end
            end
            e1 = (i == 0) ? 10'h354 : tok[i-1];
            n_tests++;
            if (tmds1 !== e1) begin
                n_fail++; $display("FAIL ctrl_tok_p1[%0d]: got %h expected %h", i, tmds1, e1);
            end
        end
    endtask

    // 0x00 three times from cnt=0, then tie cases for XOR and XNOR chaining.
    task automatic test_active_encode();
        logic [7:0] d_v [8] = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h10, 8'hF0, 8'h55, 8'h01};
        logic [9:0] e_s [8] = '{10'h100, 10'h3FF, 10'h100, 10'h105, 10'h1F0, 10'h0FA, 10'h133, 10'h1FF};
        int         e_c [8] = '{-8, 2, -6, -4, -4, -2, -2, 6};
        go_blank(3);
        // 0x0F onward must start from cnt=0 again: insert the table as
        // two runs separated by one blank cycle.
        for (int i = 0; i <= 9; i++) begin
            int k;
            k = (i < 3) ? i : i - 1;
            if (i == 3 || i == 9) begin
                blank_i = 1'b1; ctrl_i = 2'b00; data_i = 8'h00;
            end else begin
                blank_i = 1'b0; ctrl_i = 2'b00; data_i = d_v[k];
            end
            step();
            if (i != 3 && i != 9) begin
                n_tests++;
                if (tmds0 !== e_s[k] || cnt_of0() != e_c[k]) begin
                    n_fail++; $display("FAIL active_p0[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       k, tmds0, cnt_of0(), e_s[k], e_c[k]);
                end
            end
            if (i >= 1 && i != 4) begin
                int j;
                j = (i <= 3) ? i - 1 : i - 2;
                n_tests++;
                if (tmds1 !== e_s[j] || cnt_of1() != e_c[j]) begin
                    n_fail++; $display("FAIL active_p1[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       j, tmds1, cnt_of1(), e_s[j], e_c[j]);
                end
            end
        end
    endtask

    // Run of 0xFF, blank, 0xFF again: post-blank symbols restart at cnt=0.
    task automatic test_ff_blank();
        logic [7:0] d_v [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        logic       b_v [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [9:0] e_s [10] = '{10'h200, 10'h0FF, 10'h0FF, 10'h200, 10'h0FF, 10'h200,
                                 10'h354, 10'h200, 10'h0FF, 10'h0FF};
        int         e_c [10] = '{-8, -2, 4, -4, 2, -6, 0, -8, -2, 4};
        go_blank(3);
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                data_i = d_v[i]; blank_i = b_v[i]; ctrl_i = 2'b00;
            end else begin
                data_i = 8'h00; blank_i = 1'b1; ctrl_i = 2'b00;
            end
            step();
            if (i < 10) begin
                n_tests++;
                if (tmds0 !== e_s[i] || cnt_of0() != e_c[i]) begin
                    n_fail++; $display("FAIL ff_blank_p0[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i, tmds0, cnt_of0(), e_s[i], e_c[i]);
                end
            end
            if (i > 0) begin
                n_tests++;
                if (tmds1 !== e_s[i-1] || cnt_of1() != e_c[i-1]) begin
                    n_fail++; $display("FAIL ff_blank_p1[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i - 1, tmds1, cnt_of1(), e_s[i-1], e_c[i-1]);
                end
            end
        end
    endtask

    // Single-cycle alternation between blanking and active data.
    task automatic test_back_to_back();
        logic [7:0] d_v [7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       b_v [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] c_v [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11};
        logic [9:0] e_s [7] = '{10'h100, 10'h0AB, 10'h200, 10'h154, 10'h100, 10'h3FF, 10'h2AB};
        int         e_c [7] = '{-8, 0, -8, 0, -8, 2, 0};
        go_blank(3);
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                data_i = d_v[i]; blank_i = b_v[i]; ctrl_i = c_v[i];
            end else begin
                data_i = 8'h00; blank_i = 1'b1; ctrl_i = 2'b00;
            end
            step();
            if (i < 7) begin
                n_tests++;
                if (tmds0 !== e_s[i] || cnt_of0() != e_c[i]) begin
                    n_fail++; $display("FAIL b2b_p0[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i, tmds0, cnt_of0(), e_s[i], e_c[i]);
                end
            end
            if (i > 0) begin
                n_tests++;
                if (tmds1 !== e_s[i-1] || cnt_of1() != e_c[i-1]) begin
                    n_fail++; $display("FAIL b2b_p1[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i - 1, tmds1, cnt_of1(), e_s[i-1], e_c[i-1]);
                end
            end
        end
    endtask

    // Random active data: every symbol decodes back, disparity tracks the
    // symbol ones/zeros balance and stays within +-8.
    task automatic test_random();
        int         m0;
        int         m1;
        logic [7:0] prev;
        m0   = 0;
        m1   = 0;
        prev = 8'h00;
        go_blank(3);
        for (int i = 0; i < 2000; i++) begin
            data_i  = 8'($urandom_range(0, 255));
            blank_i = 1'b0;
            ctrl_i  = 2'b00;
            step();
            m0 = m0 + 2 * pop10(tmds0) - 10;
            n_tests++;
            if (decode(tmds0) !== data_i) begin
                n_fail++; $display("FAIL rand_dec_p0[%0d]: got %h expected %h", i, decode(tmds0), data_i);
            end
            n_tests++;
            if (cnt_of0() != m0 || m0 > 8 || m0 < -8) begin
                n_fail++; $display("FAIL rand_cnt_p0[%0d]: got %0d expected %0d within 8", i, cnt_of0(), m0);
            end
            if (i > 0) begin
                m1 = m1 + 2 * pop10(tmds1) - 10;
                n_tests++;
                if (decode(tmds1) !== prev) begin
                    n_fail++; $display("FAIL rand_dec_p1[%0d]: got %h expected %h", i, decode(tmds1), prev);
                end
                n_tests++;
                if (cnt_of1() != m1 || m1 > 8 || m1 < -8) begin
                    n_fail++; $display("FAIL rand_cnt_p1[%0d]: got %0d expected %0d within 8", i, cnt_of1(), m1);
                end
            end
            prev = data_i;
        end
    endtask

    // Reset pulsed mid-line: in-flight symbols are dropped, encoding
    // restarts from cnt=0 after the normal latency.
    task automatic test_reset_mid();
        logic [9:0] e_s [4] = '{10'h100, 10'h3FF, 10'h100, 10'h354};
        int         e_c [4] = '{-8, 2, -6, 0};
        go_blank(3);
        blank_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_i = 8'($urandom_range(0, 255));
            step();
        end
        rst_i  = 1'b1;
        data_i = 8'hAA;
        step();
        rst_i = 1'b0;
        n_tests++;
        if (tmds1 !== 10'h354 || tmds0 !== 10'h354) begin
            n_fail++; $display("FAIL mid_rst_sym: got %h/%h expected 354", tmds1, tmds0);
        end
        n_tests++;
        if (cnt_of1() != 0 || cnt_of0() != 0) begin
            n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d expected 0", cnt_of1(), cnt_of0());
        end
        for (int i = 0; i <= 4; i++) begin
            blank_i = (i >= 3) ? 1'b1 : 1'b0;
            ctrl_i  = 2'b00;
            data_i  = 8'h00;
            step();
            if (i < 4) begin
                n_tests++;
                if (tmds0 !== e_s[i] || cnt_of0() != e_c[i]) begin
                    n_fail++; $display("FAIL mid_rst_p0[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i, tmds0, cnt_of0(), e_s[i], e_c[i]);
                end
            end
            n_tests++;
            if (i == 0) begin
                if (tmds1 !== 10'h354 || cnt_of1() != 0) begin
                    n_fail++; $display("FAIL mid_rst_p1_s1: got %h cnt %0d expected 354 cnt 0",
                                       tmds1, cnt_of1());
                end
            end else begin
                if (tmds1 !== e_s[i-1] || cnt_of1() != e_c[i-1]) begin
                    n_fail++; $display("FAIL mid_rst_p1[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i - 1, tmds1, cnt_of1(), e_s[i-1], e_c[i-1]);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_i   = 1'b1;
        data_i  = 8'h00;
        blank_i = 1'b1;
        ctrl_i  = 2'b00;
        test_reset();
        test_ctrl_tokens();
        test_active_encode();
        test_ff_blank();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
